// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the 7-segment scan driver: segment width, blank codes,
// FSM state encodings and the anode-select helper.
package seg_scan_driver_pkg;
  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] BLANK_SEG  = 7'h7F;
  localparam logic [3:0]       ANODES_OFF = 4'hF;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SCAN  = 1'b1;

  // Active-low one-hot enable for the given digit index.
  function automatic logic [3:0] anode_sel(input logic [1:0] digit);
    return ~(4'b0001 << digit);
  endfunction
endpackage

// File: rtl/seg_scan_driver_timer.sv
// Scan timing: per-digit slot counter, digit index, frame-wrap strobe and
// the frame-based blink counter/phase.
module seg_scan_timer #(
  parameter int SCAN_DIV     = 4,
  parameter int BLINK_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_run,
  input  logic       i_drop,
  output logic [1:0] o_digit,
  output logic       o_slot_first,
  output logic       o_slot_last,
  output logic       o_wrap,
  output logic       o_phase_on
);
  localparam logic [15:0] CNT_LAST   = 16'(SCAN_DIV - 1);
  localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);

  logic [15:0] r_cnt;
  logic [1:0]  r_digit;
  logic [7:0]  r_blink;
  logic        r_phase_on;
  logic        w_slot_last;
  logic        w_wrap;

  assign w_slot_last  = (r_cnt == CNT_LAST);
  assign w_wrap       = w_slot_last && (r_digit == 2'd3);
  assign o_digit      = r_digit;
  assign o_slot_first = (r_cnt == 16'd0);
  assign o_slot_last  = w_slot_last;
  assign o_wrap       = w_wrap && i_run;
  assign o_phase_on   = r_phase_on;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_digit    <= '0;
      r_blink    <= '0;
      r_phase_on <= 1'b1;
    end else begin
      if (!i_run) begin
        r_cnt   <= '0;
        r_digit <= '0;
      end else if (w_slot_last) begin
        r_cnt   <= '0;
        r_digit <= r_digit + 2'd1;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end

      // Without a latched drop the blink machine idles in a fresh on-period.
      if (!i_drop) begin
        r_blink    <= '0;
        r_phase_on <= 1'b1;
      end else if (i_run && w_wrap) begin
        if (r_blink == BLINK_LAST) begin
          r_blink    <= '0;
          r_phase_on <= ~r_phase_on;
        end else begin
          r_blink <= r_blink + 8'd1;
        end
      end
    end
  end
endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment driver with a one-entry update buffer
// committed only at frame boundaries, plus whole-display blink on drop.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV     = 4,
  parameter int BLINK_FRAMES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEG_W-1:0] seg1_in,
  input  logic [SEG_W-1:0] seg2_in,
  input  logic [SEG_W-1:0] seg3_in,
  input  logic [SEG_W-1:0] seg4_in,
  input  logic             drop_in,
  input  logic             upd_valid,
  output logic             upd_ready,
  output logic [SEG_W-1:0] seg_n,
  output logic [3:0]       an_n,
  output logic             frame_start,
  output logic [0:0]       o_dbg_state
);
  // Handshake: an update transfers on a cycle where upd_valid && upd_ready;
  // the upstream must hold valid and data stable until that cycle.
  logic [0:0]            r_state;
  logic                  r_pend_full;
  logic [3:0][SEG_W-1:0] r_pend_seg;
  logic                  r_pend_drop;
  logic [3:0][SEG_W-1:0] r_shadow_seg;
  logic                  r_shadow_drop;
  logic                  r_upd_ready;
  logic [SEG_W-1:0]      r_seg_n;
  logic [3:0]            r_an_n;
  logic                  r_frame_start;

  logic [1:0] w_digit;
  logic       w_slot_first;
  logic       w_slot_last;
  logic       w_wrap;
  logic       w_phase_on;
  logic       w_accept;
  logic       w_commit;

  seg_scan_timer #(
    .SCAN_DIV     (SCAN_DIV),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .i_run        (r_state == ST_SCAN),
    .i_drop       (r_shadow_drop),
    .o_digit      (w_digit),
    .o_slot_first (w_slot_first),
    .o_slot_last  (w_slot_last),
    .o_wrap       (w_wrap),
    .o_phase_on   (w_phase_on)
  );

  assign w_accept = upd_valid && r_upd_ready;
  assign w_commit = r_pend_full && ((r_state == ST_BLANK) || w_wrap);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_BLANK;
      r_pend_full   <= 1'b0;
      r_pend_seg    <= '0;
      r_pend_drop   <= 1'b0;
      r_shadow_seg  <= '0;
      r_shadow_drop <= 1'b0;
      r_upd_ready   <= 1'b1;
      r_seg_n       <= BLANK_SEG;
      r_an_n        <= ANODES_OFF;
      r_frame_start <= 1'b0;
    end else begin
      // Accept needs an empty buffer and commit a full one, so they never overlap.
      if (w_accept) begin
        r_pend_seg  <= {seg4_in, seg3_in, seg2_in, seg1_in};
        r_pend_drop <= drop_in;
        r_pend_full <= 1'b1;
        r_upd_ready <= 1'b0;
      end else if (w_commit) begin
        r_pend_full <= 1'b0;
        r_upd_ready <= 1'b1;
      end

      if (w_commit) begin
        r_shadow_seg  <= r_pend_seg;
        r_shadow_drop <= r_pend_drop;
        r_state       <= ST_SCAN;
      end

      if (r_state == ST_SCAN) begin
        r_frame_start <= w_slot_first && (w_digit == 2'd0);
        if (r_shadow_drop && !w_phase_on) begin
          r_seg_n <= BLANK_SEG;
          r_an_n  <= ANODES_OFF;
        end else begin
          r_seg_n <= ~r_shadow_seg[w_digit];
          // Dark last cycle per slot keeps the next digit's segments from ghosting.
          r_an_n  <= w_slot_last ? ANODES_OFF : anode_sel(w_digit);
        end
      end else begin
        r_seg_n       <= BLANK_SEG;
        r_an_n        <= ANODES_OFF;
        r_frame_start <= 1'b0;
      end
    end
  end

  assign upd_ready   = r_upd_ready;
  assign seg_n       = r_seg_n;
  assign an_n        = r_an_n;
  assign frame_start = r_frame_start;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (SCAN_DIV=4, BLINK_FRAMES=2): idle,
// scan sequence, mid-frame update with stall, blink, and reset abort.
module tb_seg_scan_driver;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg1_in = '0;
  logic [6:0] seg2_in = '0;
  logic [6:0] seg3_in = '0;
  logic [6:0] seg4_in = '0;
  logic       drop_in = 1'b0;
  logic       upd_valid = 1'b0;
  logic       upd_ready;
  logic [6:0] seg_n;
  logic [3:0] an_n;
  logic       frame_start;
  logic [0:0] dbg_state;

  int total = 0;
  int bad = 0;
  int p = 0;
  logic [6:0] m_seg[4];

  seg_scan_driver #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg1_in     (seg1_in),
    .seg2_in     (seg2_in),
    .seg3_in     (seg3_in),
    .seg4_in     (seg4_in),
    .drop_in     (drop_in),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .frame_start (frame_start),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s p=%0d observed=%h expected=%h", tag, p, obs, exp);
    end
  endtask

  task automatic set_upd(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c,
                         input logic [6:0] d, input logic drop);
    seg1_in = a;
    seg2_in = b;
    seg3_in = c;
    seg4_in = d;
    drop_in = drop;
  endtask

  task automatic chk_blank(input string tag, input logic rdy);
    chk({tag, "_seg_n"}, 32'(seg_n), 32'h7F);
    chk({tag, "_an_n"}, 32'(an_n), 32'hF);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'h0);
    chk({tag, "_upd_ready"}, 32'(upd_ready), 32'(rdy));
  endtask

  // Expected outputs at position pos of a 16-cycle frame (4 slots x 4 cycles).
  task automatic check_pos(input int pos, input logic blank, input logic rdy);
    int k;
    int d;
    int c;
    logic [3:0] ea;
    logic [6:0] es;
    k = pos % 16;
    d = k / 4;
    c = k % 4;
    if (blank) begin
      ea = 4'hF;
      es = 7'h7F;
    end else begin
      ea = (c == 3) ? 4'hF : ~(4'b0001 << d);
      es = ~m_seg[d];
    end
    chk("an_n", 32'(an_n), 32'(ea));
    chk("seg_n", 32'(seg_n), 32'(es));
    chk("frame_start", 32'(frame_start), 32'(k == 0));
    chk("upd_ready", 32'(upd_ready), 32'(rdy));
  endtask

  initial begin
    // Reset and idle
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_blank("reset", 1'b1);
    chk("reset_state", 32'(dbg_state), 32'h0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_blank("idle", 1'b1);
    end

    // First accept from BLANK: lit two cycles after the accept edge
    set_upd(7'h3F, 7'h06, 7'h5B, 7'h4F, 1'b0);
    upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
    chk("acc_ready", 32'(upd_ready), 32'h0);
    chk("acc_an_n", 32'(an_n), 32'hF);
    tick();
    chk("commit_ready", 32'(upd_ready), 32'h1);
    chk("commit_an_n", 32'(an_n), 32'hF);
    chk("commit_fs", 32'(frame_start), 32'h0);
    chk("commit_state", 32'(dbg_state), 32'h1);
    tick();
    m_seg = '{7'h3F, 7'h06, 7'h5B, 7'h4F};
    p = 0;
    while (p < 38) begin
      check_pos(p, 1'b0, 1'b1);
      // Mid-frame update offered at frame position 5
      if (p == 37) begin
        set_upd(7'h06, 7'h5B, 7'h4F, 7'h66, 1'b0);
        upd_valid = 1'b1;
      end
      tick();
      p++;
    end

    // Second update held while the first is pending; it transfers at p=47
    set_upd(7'h6D, 7'h7D, 7'h07, 7'h7F, 1'b0);
    while (p < 80) begin
      if (p == 48) begin
        upd_valid = 1'b0;
        m_seg = '{7'h06, 7'h5B, 7'h4F, 7'h66};
      end
      if (p == 64) m_seg = '{7'h6D, 7'h7D, 7'h07, 7'h7F};
      check_pos(p, 1'b0, (p % 16 == 15) || (p >= 64));
      tick();
      p++;
    end

    // Blink update (drop=1), then drop=0 update offered during an off phase
    set_upd(7'h3F, 7'h06, 7'h5B, 7'h4F, 1'b1);
    upd_valid = 1'b1;
    check_pos(p, 1'b0, 1'b1);
    tick();
    p++;
    upd_valid = 1'b0;
    while (p < 240) begin
      if (p == 96) m_seg = '{7'h3F, 7'h06, 7'h5B, 7'h4F};
      if (p == 208) m_seg = '{7'h66, 7'h6D, 7'h7D, 7'h07};
      check_pos(p, (p >= 96) && (p < 208) && (((p - 96) / 32) % 2 == 1),
                ((p >= 95) && (p < 193)) || (p >= 207));
      if (p == 192) begin
        set_upd(7'h66, 7'h6D, 7'h7D, 7'h07, 1'b0);
        upd_valid = 1'b1;
      end
      tick();
      p++;
      upd_valid = 1'b0;
    end

    // Pending update, then reset in the middle of the digit-2 slot
    set_upd(7'h7F, 7'h6F, 7'h77, 7'h7C, 1'b0);
    upd_valid = 1'b1;
    check_pos(p, 1'b0, 1'b1);
    tick();
    p++;
    upd_valid = 1'b0;
    while (p < 250) begin
      check_pos(p, 1'b0, 1'b0);
      tick();
      p++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_blank("rst_mid", 1'b1);
    chk("rst_mid_state", 32'(dbg_state), 32'h0);
    for (int i = 0; i < 40; i++) begin
      tick();
      chk_blank("after_rst", 1'b1);
    end

    // Fresh accept after reset scans the new codes
    set_upd(7'h7F, 7'h6F, 7'h77, 7'h7C, 1'b0);
    upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
    tick();
    tick();
    m_seg = '{7'h7F, 7'h6F, 7'h77, 7'h7C};
    for (int i = 0; i < 16; i++) begin
      p = i;
      check_pos(p, 1'b0, 1'b1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Physical-side consumer of the four parallel 7-segment codes and the drop_activated flag produced by the baggage drop display path.
- Buffers one pending update and commits it only at frame boundaries, so the display never tears.
- Time-multiplexes the four digits onto one shared active-low segment bus with active-low one-hot digit enables.
- While drop_activated is latched, blinks the whole display.

Parameters:
- SCAN_DIV, 4: clock cycles each digit is driven; legal range 2..65535.
- BLINK_FRAMES, 8: full scan frames per blink phase (on or off); legal range 1..255.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- seg1_in  input  7  segment code for digit 0, active-high, bit0 = segment a.
- seg2_in  input  7  segment code for digit 1.
- seg3_in  input  7  segment code for digit 2.
- seg4_in  input  7  segment code for digit 3.
- drop_in  input  1  drop_activated flag belonging to the same update.
- upd_valid  input  1  update offered this cycle.
- upd_ready  output  1  pending buffer can accept an update.
- seg_n  output  7  physical segment lines, active-low.
- an_n  output  4  digit enables, active-low, one-hot or all-high.
- frame_start  output  1  one-cycle pulse when a digit-0 slot begins.

Behaviour:
- Reset values (rst=1 at a clock edge):
  - state=BLANK, seg_n=7'h7F, an_n=4'hF, upd_ready=1, frame_start=0.
  - Pending buffer empty; shadow registers zeroed; scan counter, digit index and blink counter zeroed; blink phase = on.
  - Reset mid-frame aborts the frame immediately and discards any pending update.
- Pending buffer:
  - One entry: 4x7 segment bits plus drop.
  - upd_ready = ~pending_full, registered.
  - Transfer occurs on upd_valid & upd_ready; pending_full sets the next cycle.
  - Inputs are sampled only at transfer. upd_valid without upd_ready is ignored, so the upstream must hold valid.
- Commit:
  - pending → shadow at a frame boundary: the cycle in which the digit index wraps 3→0, or any cycle while in BLANK.
  - pending_full clears that same cycle, so upd_ready rises the following cycle.
  - Accept and commit in the same cycle is impossible, because accept requires the buffer to be empty.
- State BLANK:
  - Outputs blanked.
  - On the first commit, go to SCAN with digit index 0 and scan counter 0. frame_start pulses in the first SCAN cycle.
- State SCAN:
  - Digit i is driven for SCAN_DIV cycles: an_n = ~(1<<i), seg_n = ~shadow_seg[i].
  - Total latency from accept to first lit output is 2 cycles from BLANK. From SCAN it is up to one frame (4*SCAN_DIV cycles) plus 1.
  - Scan counter counts 0..SCAN_DIV-1; at terminal count the digit index increments modulo 4.
  - frame_start = 1 in the first cycle of every digit-0 slot.
  - SCAN never returns to BLANK except via rst.
- Blink:
  - The blink counter counts frames (increments at each 3→0 wrap) 0..BLINK_FRAMES-1. At wrap the phase toggles.
  - If shadow_drop=1 and phase=off: an_n=4'hF and seg_n=7'h7F, while the scan timing continues unchanged.
  - If shadow_drop=0: phase is forced to on and the blink counter is held at 0.
  - A commit that changes shadow_drop 0→1 starts with phase on and a full BLINK_FRAMES on-period.
- Outputs are registered; no combinational path from inputs to seg_n, an_n or upd_ready.
- Anti-ghosting: in the last cycle of each digit slot, an_n is forced to 4'hF.

Decomposition:
- Shared package holds:
  - Segment width constant SEG_W=7.
  - BLANK_SEG=7'h7F and ANODES_OFF=4'hF.
  - State enum {BLANK, SCAN}.
- Natural sub-module: seg_scan_timer (scan counter, digit index, frame-wrap strobe, blink counter/phase).
- The top holds the pending buffer, the shadow registers and the output muxing.

Test Plan:
- Reset, then hold idle 20 cycles → seg_n=7F, an_n=F, upd_ready=1, frame_start never pulses.
- Accept an update (SCAN_DIV=4) with seg1..4=3F,06,5B,4F and drop=0 → 2 cycles later an_n=E, seg_n=40 for 3 cycles, then an_n=F for 1 cycle. The next slot shows an_n=D, seg_n=79; the full sequence repeats every 16 cycles with frame_start at each digit-0 start.
- Mid-frame update while scanning (offer at cycle 5 of a frame) → upd_ready drops 1 cycle after accept. The display keeps the old codes until the 3→0 wrap, then switches to the new codes; upd_ready rises the next cycle. A second update offered in between is stalled (valid held, no transfer).
- drop=1 update with BLINK_FRAMES=2 → digits lit for 2 frames, fully blank (an_n=F) for 2 frames, repeating. frame_start still pulses every 16 cycles. A later drop=0 update restores steady display from the next frame.
- Assert rst for 1 cycle in the middle of the digit-2 slot with a pending update → next cycle all outputs at reset values, upd_ready=1. The pending update is lost; display stays blank until a new accept.
